sd_fir_slice_engine: RTL
========================

Name: sd_fir_slice_engine

Overview:
- Parametrised successor of the two-stage sigma-delta FIR slice.
- Holds per-channel accumulator state in an internal RAM and a banked coefficient RAM with two coefficients per word.
- On a start command, an internal FSM sequences all tap pairs of one channel and adds or subtracts both coefficients per cycle according to the 1-bit streams.
- Writes the sum back and reports it with a done pulse. Sits between the sigma-delta bit-history buffer and the decimation/output logic.

Parameters:
ACC_W, 24, accumulator/state width (>= COEF_W+2)
COEF_W, 18, signed coefficient width
CHANNELS, 16, number of state words (channels)
TAP_PAIRS, 256, coefficient pairs per pass (>= 2)
BANKS, 2, coefficient banks (filter modes)

Ports:
clock_200  in  1  system clock
reset  in  1  asynchronous, active-high reset
coefficient_write_adr  in  clog2(BANKS*TAP_PAIRS)  coefficient write address {bank,pair}
coefficient_write_data  in  2*COEF_W  {coef_A, coef_B}
coefficient_write_en  in  1  coefficient write strobe
start  in  1  start pulse; accepted only in IDLE
start_channel  in  clog2(CHANNELS)  channel to process
start_bank  in  clog2(BANKS)  coefficient bank
start_clear  in  1  1 = accumulate from 0; 0 = from stored state
stream_adr  out  clog2(TAP_PAIRS)  tap-pair index requested from the bit-history buffer
sigma_delta_stream_A  in  1  bit for coef_A of the pair on stream_adr, one cycle late
sigma_delta_stream_B  in  1  bit for coef_B, same timing
busy  out  1  pass in progress
done  out  1  one-cycle result-valid pulse
result  out  ACC_W  signed result of the last pass
result_channel  out  clog2(CHANNELS)  channel of result
overflow  out  1  sticky overflow of current/last pass

Behaviour:
- Reset (async, asserted): FSM to IDLE. busy=0, done=0, result=0, result_channel=0, overflow=0, stream_adr=0, pair counter=0.
- Reset does not clear the state RAM or the coefficient RAM. The first pass per channel after power-up must use start_clear=1.
- States: IDLE, RUN, DRAIN.
- IDLE + start at edge T:
  - latch channel and bank; clear overflow;
  - acc <= 0 if start_clear, else stateRAM[start_channel] (combinational read);
  - counter=0; go to RUN.
- start outside IDLE is ignored, with no side effects.
- RUN (cycles T+1 .. T+TAP_PAIRS):
  - coefficient read address = {bank, counter}; stream_adr = counter; counter increments.
  - Exits to DRAIN after counter = TAP_PAIRS-1.
- Datapath:
  - Coefficient RAM output is registered, so data for pair k arrives one cycle after its address, together with the stream bits for k.
  - Accumulate in cycles T+2 .. T+TAP_PAIRS+1 (last one in DRAIN): acc <= acc (bitA ? + : -) sext(coef_A) (bitB ? + : -) sext(coef_B). Bit 1 = add.
  - Sum is computed at ACC_W+2 bits.
- Overflow: sum outside the ACC_W signed range sets overflow (sticky until the next accepted start).
- DRAIN exit edge:
  - stateRAM[channel] <= final acc; result <= final acc; result_channel <= channel;
  - go to IDLE.
- done=1 for exactly cycle T+TAP_PAIRS+2, with busy=0 in that cycle.
- busy=1 for cycles T+1 .. T+TAP_PAIRS+1.
- A start in the done cycle is accepted (back-to-back passes, TAP_PAIRS+2 cycle period).
- result and overflow hold until the next pass completes, or the next start clears overflow.
- Coefficient write during a pass is allowed. A write to the address being read in the same cycle returns old data; later reads see new data.
- Reset asserted mid-pass: pass aborted, no writeback, state RAM unchanged.

Optional Feature:
SD_FIR_SLICE_SAT_EN
- Defined: each accumulate step clamps to +(2^(ACC_W-1)-1) / -2^(ACC_W-1) on overflow; overflow is still flagged; the clamped value is written back.
- Undefined: two's-complement wrap to ACC_W bits; overflow is flagged only.

Test Plan:
Bench parameters: TAP_PAIRS=4, CHANNELS=4, BANKS=2.
- Bank 0 all coef_A=1, coef_B=2; ch0, start_clear=1, all stream bits 1 -> done at T+6, result=12, result_channel=0, overflow=0, busy high T+1..T+5.
- Same setup, all stream bits 0, ch1 -> result=-12 (0xFFFFF4); stateRAM[1]=-12.
- ch0 again, start_clear=0, bits 1 -> result=24. Then ch1, start_clear=0, A bits 1 and B bits 0 -> result=-16. Other channels are untouched.
- ACC_W=20, coefficients 131071/131071, bits 1, start_clear=1:
  - without macro -> result=-8, overflow=1;
  - with SD_FIR_SLICE_SAT_EN -> result=524287, overflow=1.
- start pulsed at T+2 for ch2 -> ignored, ch0 pass completes unchanged. start in the done cycle -> accepted, next done 6 cycles later.
- Reset asserted at T+3 -> busy=0, done=0, result=0 immediately; stateRAM[channel] keeps its pre-pass value (check by a start_clear=0 pass with all-zero coefficients in bank 1).

Source files
------------

// File: rtl/sd_fir_slice_engine_if.sv
// Command/result bus of the sigma-delta FIR slice engine: coefficient writes, pass start, bit-history handshake, result.
// Latency: none (wires only); pass timing is defined by sd_fir_slice_engine.
// Backpressure: none; start is sampled only while the engine is idle, busy tells the controller when that is.
// Ports: master = controller/bench side, slave = engine side.
interface sd_fir_slice_engine_if #(
  parameter int ACC_W     = 24,
  parameter int COEF_W    = 18,
  parameter int CHANNELS  = 16,
  parameter int TAP_PAIRS = 256,
  parameter int BANKS     = 2
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PR_W = $clog2(TAP_PAIRS);
  localparam int BK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int CA_W = $clog2(BANKS * TAP_PAIRS);

  logic [CA_W-1:0]     coefficient_write_adr;
  logic [2*COEF_W-1:0] coefficient_write_data;
  logic                coefficient_write_en;
  logic                start;
  logic [CH_W-1:0]     start_channel;
  logic [BK_W-1:0]     start_bank;
  logic                start_clear;
  logic [PR_W-1:0]     stream_adr;
  logic                sigma_delta_stream_A;
  logic                sigma_delta_stream_B;
  logic                busy;
  logic                done;
  logic [ACC_W-1:0]    result;
  logic [CH_W-1:0]     result_channel;
  logic                overflow;

  modport master (
    output coefficient_write_adr, coefficient_write_data, coefficient_write_en,
    output start, start_channel, start_bank, start_clear,
    output sigma_delta_stream_A, sigma_delta_stream_B,
    input  stream_adr, busy, done, result, result_channel, overflow
  );

  modport slave (
    input  coefficient_write_adr, coefficient_write_data, coefficient_write_en,
    input  start, start_channel, start_bank, start_clear,
    input  sigma_delta_stream_A, sigma_delta_stream_B,
    output stream_adr, busy, done, result, result_channel, overflow
  );
endinterface

// File: rtl/sd_fir_slice_engine.sv
// Sigma-delta FIR slice: per pass, sums +/-coef_A and +/-coef_B over all tap pairs of one channel into its stored state.
// Latency: start at edge T -> done pulse in cycle T+TAP_PAIRS+2; back-to-back passes every TAP_PAIRS+2 cycles.
// Backpressure: none; start is ignored unless idle (busy=0), stream bits must follow stream_adr by exactly one cycle.
// Ports: clock_200 (clock), reset (async active-high), bus (sd_fir_slice_engine_if.slave).
// Optional: define SD_FIR_SLICE_SAT_EN to saturate each accumulate step instead of wrapping.
module sd_fir_slice_engine #(
  parameter int ACC_W     = 24,
  parameter int COEF_W    = 18,
  parameter int CHANNELS  = 16,
  parameter int TAP_PAIRS = 256,
  parameter int BANKS     = 2
) (
  input  logic                  clock_200,
  input  logic                  reset,
  sd_fir_slice_engine_if.slave  bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PR_W  = $clog2(TAP_PAIRS);
  localparam int BK_W  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int CA_W  = $clog2(BANKS * TAP_PAIRS);
  localparam int SUM_W = ACC_W + 2;

`ifdef SD_FIR_SLICE_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                    state;
  logic [PR_W-1:0]           pair_cnt;
  logic [CH_W-1:0]           chan_q;
  logic [BK_W-1:0]           bank_q;
  logic signed [ACC_W-1:0]   acc;
  logic                      coef_vld;
  logic                      busy_q;
  logic                      done_q;
  logic [ACC_W-1:0]          result_q;
  logic [CH_W-1:0]           result_ch_q;
  logic                      ovf_q;

  logic [2*COEF_W-1:0]       coef_mem [BANKS*TAP_PAIRS];
  logic [ACC_W-1:0]          state_mem [CHANNELS];
  logic signed [COEF_W-1:0]  coef_a_q;
  logic signed [COEF_W-1:0]  coef_b_q;
  logic [CA_W-1:0]           coef_rd_adr;

  logic signed [SUM_W-1:0]   ext_acc;
  logic signed [SUM_W-1:0]   ext_a;
  logic signed [SUM_W-1:0]   ext_b;
  logic signed [SUM_W-1:0]   sum;
  logic                      sum_ovf;
  logic signed [ACC_W-1:0]   acc_next;

  // Linear bank*TAP_PAIRS+pair addressing; identical to {bank,pair} when TAP_PAIRS is a power of two.
  assign coef_rd_adr = CA_W'(bank_q) * CA_W'(TAP_PAIRS) + CA_W'(pair_cnt);

  // Registered coefficient read: data for pair k lines up with the stream bits for k one cycle later.
  // A write to the address being read in the same edge returns the old word (nonblocking ordering).
  always_ff @(posedge clock_200) begin
    if (bus.coefficient_write_en) begin
      coef_mem[bus.coefficient_write_adr] <= bus.coefficient_write_data;
    end
    {coef_a_q, coef_b_q} <= coef_mem[coef_rd_adr];
  end

  // Two-coefficient add/subtract at ACC_W+2 bits so the true sum is always representable.
  always_comb begin
    ext_acc  = {{2{acc[ACC_W-1]}}, acc};
    ext_a    = {{(SUM_W-COEF_W){coef_a_q[COEF_W-1]}}, coef_a_q};
    ext_b    = {{(SUM_W-COEF_W){coef_b_q[COEF_W-1]}}, coef_b_q};
    sum      = ext_acc
             + (bus.sigma_delta_stream_A ? ext_a : -ext_a)
             + (bus.sigma_delta_stream_B ? ext_b : -ext_b);
    // In range only if the bits above the ACC_W sign bit all match it.
    sum_ovf  = !((&sum[SUM_W-1:ACC_W-1]) || !(|sum[SUM_W-1:ACC_W-1]));
    acc_next = sum[ACC_W-1:0];
`ifdef SD_FIR_SLICE_SAT_EN
    if (sum_ovf) begin
      acc_next = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

  always_ff @(posedge clock_200 or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pair_cnt    <= '0;
      chan_q      <= '0;
      bank_q      <= '0;
      acc         <= '0;
      coef_vld    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_ch_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      // Coefficient word fetched in a RUN cycle is consumed in the following cycle.
      coef_vld <= (state == S_RUN);
      if (coef_vld) begin
        acc <= acc_next;
        if (sum_ovf) begin
          ovf_q <= 1'b1;
        end
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            chan_q   <= bus.start_channel;
            bank_q   <= bus.start_bank;
            ovf_q    <= 1'b0;
            acc      <= bus.start_clear ? '0 : state_mem[bus.start_channel];
            pair_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (pair_cnt == PR_W'(TAP_PAIRS - 1)) begin
            pair_cnt <= '0;
            state    <= S_DRAIN;
          end else begin
            pair_cnt <= pair_cnt + PR_W'(1);
          end
        end
        S_DRAIN: begin
          // Last pair is accumulated in this cycle, so the result is acc_next, not acc.
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          result_q    <= acc_next;
          result_ch_q <= chan_q;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // State RAM has no reset; an aborted pass never reaches DRAIN and so never writes back.
  always_ff @(posedge clock_200) begin
    if (state == S_DRAIN) begin
      state_mem[chan_q] <= acc_next;
    end
  end

  assign bus.stream_adr     = pair_cnt;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.result         = result_q;
  assign bus.result_channel = result_ch_q;
  assign bus.overflow       = ovf_q;
endmodule
